// File: rtl/serial_add_sub_pkg.sv
// Shared state encodings, op codes and default width for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'b00,
    SAS_RUN  = 2'b01,
    SAS_DONE = 2'b10
  } sas_state_t;

  localparam logic SAS_OP_ADD = 1'b0;
  localparam logic SAS_OP_SUB = 1'b1;

endpackage

// File: rtl/full_add_sub_cell.sv
// Combinational 1-bit cell: full adder when sub=0, full subtractor (borrow chain) when sub=1.
module full_add_sub_cell
  import serial_add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic r,
  output logic cout
);

  always_comb begin
    r = a ^ b ^ cin;
    if (sub == SAS_OP_ADD) begin
      cout = (a & b) | (cin & (a ^ b));
    end else begin
      cout = (~a & b) | (~(a ^ b) & cin);
    end
  end

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract: one bit per clock, LSB first, START/DONE handshake.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);

  sas_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             op_reg;
  logic             carry_reg;
  logic             bit_r, bit_c;
  logic             accept, last;
  logic [WIDTH-1:0] y_final;

  full_add_sub_cell u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .sub  (op_reg),
    .r    (bit_r),
    .cout (bit_c)
  );

  assign accept  = START && (state_reg != SAS_RUN);
  assign last    = (state_reg == SAS_RUN) && (cnt_reg == CNT_W'(WIDTH - 1));
  assign y_final = {bit_r, res_reg[WIDTH-1:1]};
  assign BUSY    = (state_reg == SAS_RUN);
  assign DONE    = (state_reg == SAS_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SAS_IDLE: if (START) state_next = SAS_RUN;
      SAS_RUN:  if (last) state_next = SAS_DONE;
      SAS_DONE: state_next = START ? SAS_RUN : SAS_IDLE;
      default:  state_next = SAS_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= SAS_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cnt_reg   <= '0;
      op_reg    <= SAS_OP_ADD;
      carry_reg <= 1'b0;
      Y         <= '0;
      CO        <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg     <= A;
        b_reg     <= B;
        op_reg    <= SUB;
        carry_reg <= 1'b0;
        cnt_reg   <= '0;
      end else if (state_reg == SAS_RUN) begin
        a_reg     <= a_reg >> 1;
        b_reg     <= b_reg >> 1;
        res_reg   <= y_final;
        carry_reg <= bit_c;
        cnt_reg   <= cnt_reg + CNT_W'(1);
        // On the last bit the operand LSBs are the original sign bits.
        if (last) begin
          Y  <= y_final;
          CO <= bit_c;
          V  <= (op_reg == SAS_OP_SUB)
                  ? ((a_reg[0] != b_reg[0]) && (bit_r != a_reg[0]))
                  : ((a_reg[0] == b_reg[0]) && (bit_r != a_reg[0]));
          Z  <= (y_final == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Randomised and directed check of serial_add_sub against a plain-arithmetic reference model.
module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [31:0] a, b, y;
  logic        co, v, z, busy, done;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] prev_y;
  logic [31:0] ey;
  logic        eco, ev, ez;

  serial_add_sub dut (
    .CLK(clk), .RST(rst), .START(start), .SUB(sub), .A(a), .B(b),
    .Y(y), .CO(co), .V(v), .Z(z), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic ms,
                       output logic [31:0] my, output logic mco, output logic mv, output logic mz);
    longint sa, sb, sr;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (ms) begin
      my  = ma - mb;
      mco = (ma < mb);
      sr  = sa - sb;
    end else begin
      {mco, my} = {1'b0, ma} + {1'b0, mb};
      sr  = sa + sb;
    end
    mv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    mz = (my == 32'd0);
  endtask

  task automatic start_op(input logic [31:0] oa, input logic [31:0] ob, input logic os);
    start = 1'b1; a = oa; b = ob; sub = os;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
  endtask

  // Called #1 after the accepting edge; returns #1 after the DONE edge (or timeout).
  task automatic wait_done(input string tag, input int inject_at);
    int cycles = 0;
    int busy_n = 0;
    bit hold_ok = 1'b1;
    if (busy) busy_n++;
    while (!done && cycles < 40) begin
      if (y !== prev_y) hold_ok = 1'b0;
      if (cycles == inject_at) begin
        start = 1'b1; a = 32'd9; b = 32'd4; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_n++;
    end
    start = 1'b0;
    check({tag, ".lat"}, cycles, 32);
    check({tag, ".busy"}, busy_n, 32);
    check({tag, ".hold"}, 32'(hold_ok), 1);
    check({tag, ".y"}, y, ey);
    check({tag, ".flags"}, {co, v, z}, {eco, ev, ez});
    prev_y = ey;
  endtask

  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob, input logic os);
    model(oa, ob, os, ey, eco, ev, ez);
    start_op(oa, ob, os);
    wait_done(tag, -1);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int dn;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    prev_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", y, 0);
    check("rst.flags", {co, v, z, busy, done}, 5'b0);
    rst = 1'b0;

    run_op("add5_3", 32'h5, 32'h3, 1'b0);
    run_op("sub5_3", 32'h5, 32'h3, 1'b1);
    run_op("sub3_5", 32'h3, 32'h5, 1'b1);
    run_op("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0);
    run_op("sub_ovf", 32'h80000000, 32'h1, 1'b1);
    run_op("sub_eq", 32'h12345678, 32'h12345678, 1'b1);

    // START during RUN is ignored; START in the DONE cycle is accepted.
    model(32'd1, 32'd1, 1'b0, ey, eco, ev, ez);
    start_op(32'd1, 32'd1, 1'b0);
    wait_done("ign", 10);
    check("ign.done", 32'(done), 1);
    start = 1'b1; a = 32'd2; b = 32'd2; sub = 1'b0;
    model(32'd2, 32'd2, 1'b0, ey, eco, ev, ez);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy", 32'(busy), 1);
    check("b2b.holdy", y, 32'd2);
    wait_done("b2b", -1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) rb = -ra;
      run_op($sformatf("rnd%0d", i), ra, rb, rs);
    end

    // Reset mid-operation aborts with no DONE.
    run_op("pre_rst", 32'h5, 32'h3, 1'b0);
    start_op(32'hABCD, 32'h1234, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.y", y, 0);
    check("abort.flags", {co, v, z, busy, done}, 5'b0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    check("abort.nodone", dn, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
